// File: rtl/fu_result_arbiter_pkg.sv
// fu_result_arbiter_pkg: shared FU indices, default sizes and broadcast-queue entry width
package fu_result_arbiter_pkg;
  localparam int NUM_FU = 8;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH = 7;
  localparam int Q_WIDTH = TAG_WIDTH + DATA_WIDTH;
  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    XOR = 4'd2,
    SRL = 4'd3,
    SRA = 4'd4,
    OR  = 4'd5,
    AND = 4'd6
  } fu_id_e;
endpackage

// File: rtl/fu_result_arbiter_pick.sv
// rr_priority_pick: first set request at or after ptr_i, wrapping from N-1 to 0
//   req_i   : request vector
//   ptr_i   : search start index
//   valid_o : any request set
//   idx_o   : chosen index (0 when no request)
module rr_priority_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) idx_o = W'((int'(ptr_i) + k) % N);
  end
endmodule

// File: rtl/fu_result_arbiter.sv
// fu_result_arbiter: round-robin selection of one finished FU result per cycle into the broadcast queue
//   fu_done/fu_result/fu_tag : per-FU valid, packed results and tags
//   fu_ack                   : one-cycle registered ack, one cycle after the write
//   queue_full               : broadcast FIFO back-pressure
//   q_wr_en/q_din            : combinational FIFO write, data {tag, result}
//   stall_count              : saturating count of cycles blocked by queue_full
module fu_result_arbiter
  import fu_result_arbiter_pkg::*;
#(
  parameter int NUM_FU = fu_result_arbiter_pkg::NUM_FU,
  parameter int DATA_WIDTH = fu_result_arbiter_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH = fu_result_arbiter_pkg::TAG_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_FU-1:0]               fu_done,
  input  logic [NUM_FU*DATA_WIDTH-1:0]    fu_result,
  input  logic [NUM_FU*TAG_WIDTH-1:0]     fu_tag,
  output logic [NUM_FU-1:0]               fu_ack,
  input  logic                            queue_full,
  output logic                            q_wr_en,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] q_din,
  output logic [15:0]                     stall_count
);
  localparam int PW = $clog2(NUM_FU);
  logic [PW-1:0] ptr_q, ptr_d, gidx;
  logic [NUM_FU-1:0] mask_q, mask_d, eligible;
  logic [15:0] stall_q, stall_d;
  logic pick_valid, grant;
  // the FU acked this cycle is masked so its lingering done cannot be written twice
  assign eligible = fu_done & ~mask_q;
  rr_priority_pick #(.N(NUM_FU), .W(PW)) u_pick (
    .req_i(eligible),
    .ptr_i(ptr_q),
    .valid_o(pick_valid),
    .idx_o(gidx)
  );
  always_comb begin
    grant = pick_valid & ~queue_full & ~rst;
    q_wr_en = grant;
    q_din = grant ? {fu_tag[gidx*TAG_WIDTH +: TAG_WIDTH], fu_result[gidx*DATA_WIDTH +: DATA_WIDTH]} : '0;
    mask_d = grant ? {{(NUM_FU-1){1'b0}}, 1'b1} << gidx : '0;
    ptr_d = grant ? (gidx == PW'(NUM_FU - 1) ? '0 : gidx + 1'b1) : ptr_q;
    stall_d = (queue_full & |fu_done & ~&stall_q) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      mask_q <= '0;
      stall_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      mask_q <= mask_d;
      stall_q <= stall_d;
    end
  end
  // the grant mask doubles as the ack register: both are one-hot of last cycle's grant
  assign fu_ack = mask_q;
  assign stall_count = stall_q;
endmodule

// File: tb/tb_fu_result_arbiter.sv
// tb_fu_result_arbiter: directed and randomized checks of fu_result_arbiter against a behavioural model
module tb_fu_result_arbiter;
  localparam int N = 8, DW = 32, TW = 7;
  logic clk = 1'b0, rst, queue_full, q_wr_en;
  logic [N-1:0] fu_done, fu_ack;
  logic [N*DW-1:0] fu_result;
  logic [N*TW-1:0] fu_tag;
  logic [TW+DW-1:0] q_din;
  logic [15:0] stall_count;
  logic [DW-1:0] res [N];
  logic [TW-1:0] tag [N];
  int checks = 0, failures = 0;
  int m_ptr = 0, m_last = -1, m_stall = 0;
  logic obs_wr;
  logic [TW+DW-1:0] obs_din;
  logic [N-1:0] obs_ack;
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < N; i++) begin
      fu_result[i*DW +: DW] = res[i];
      fu_tag[i*TW +: TW] = tag[i];
    end
  fu_result_arbiter dut (
    .clk(clk), .rst(rst), .fu_done(fu_done), .fu_result(fu_result), .fu_tag(fu_tag),
    .fu_ack(fu_ack), .queue_full(queue_full), .q_wr_en(q_wr_en), .q_din(q_din),
    .stall_count(stall_count)
  );
  task automatic check(input string t, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask
  function automatic logic [N-1:0] ack_exp();
    logic [N-1:0] one = 1;
    return m_last >= 0 ? one << m_last : '0;
  endfunction
  task automatic cycle(input string t);
    int g;
    logic [N-1:0] el;
    logic [TW+DW-1:0] ed;
    @(negedge clk);
    el = fu_done & ~ack_exp();
    g = -1;
    if (!rst && !queue_full)
      for (int k = 0; k < N; k++)
        if (g < 0 && el[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    ed = '0;
    if (g >= 0) ed = {tag[g], res[g]};
    obs_wr = q_wr_en;
    obs_din = q_din;
    obs_ack = fu_ack;
    check({t, ":wr"}, 64'(q_wr_en), 64'(g >= 0));
    check({t, ":din"}, 64'(q_din), 64'(ed));
    check({t, ":ack"}, 64'(fu_ack), 64'(ack_exp()));
    check({t, ":stall"}, 64'(stall_count), 64'(m_stall));
    @(posedge clk);
    if (rst) begin
      m_ptr = 0;
      m_last = -1;
      m_stall = 0;
    end else begin
      if (queue_full && |fu_done && m_stall < 65535) m_stall++;
      m_last = g;
      if (g >= 0) m_ptr = (g + 1) % N;
    end
    #1;
  endtask
  initial begin
    logic [N-1:0] a, pa;
    rst = 1'b1;
    fu_done = '0;
    queue_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      res[i] = '0;
      tag[i] = '0;
    end
    cycle("rst0");
    cycle("rst1");
    check("rst_ack", 64'(obs_ack), 64'(0));
    check("rst_wr", 64'(obs_wr), 64'(0));
    check("rst_stall", 64'(stall_count), 64'(0));
    rst = 1'b0;
    res[0] = 32'h1234;
    tag[0] = 7'd5;
    fu_done = 8'h01;
    cycle("t32a");
    check("t32_wr", 64'(obs_wr), 64'(1));
    check("t32_din", 64'(obs_din), 64'({7'd5, 32'h1234}));
    cycle("t32b");
    check("t32_ack", 64'(obs_ack), 64'(8'h01));
    check("t32_nowr", 64'(obs_wr), 64'(0));
    fu_done = '0;
    cycle("t32c");
    rst = 1'b1;
    cycle("t33rst");
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      res[i] = $urandom;
      tag[i] = TW'(i);
    end
    fu_done = '1;
    for (int k = 0; k < N; k++) begin
      fu_done &= ~ack_exp();
      cycle("t33");
      check("t33_wr", 64'(obs_wr), 64'(1));
      check("t33_idx", 64'(obs_din[DW +: TW]), 64'(k));
    end
    fu_done &= ~ack_exp();
    cycle("t33z");
    check("t33_done", 64'(obs_wr), 64'(0));
    for (int k = 0; k < N; k++) begin
      fu_done = 8'h44 & ~ack_exp();
      cycle("t34");
      check("t34_wr", 64'(obs_wr), 64'(1));
      check("t34_idx", 64'(obs_din[DW +: TW]), 64'(k % 2 ? 6 : 2));
    end
    fu_done = '0;
    cycle("t34z");
    rst = 1'b1;
    cycle("t35rst");
    rst = 1'b0;
    fu_done = 8'h10;
    queue_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle("t35full");
      check("t35_nowr", 64'(obs_wr), 64'(0));
      check("t35_noack", 64'(obs_ack), 64'(0));
    end
    queue_full = 1'b0;
    cycle("t35rel");
    check("t35_wr", 64'(obs_wr), 64'(1));
    check("t35_idx", 64'(obs_din[DW +: TW]), 64'(4));
    check("t35_stall", 64'(stall_count), 64'(10));
    fu_done = '0;
    cycle("t35z");
    fu_done = 8'h08;
    cycle("t36g");
    check("t36_idx3", 64'(obs_din[DW +: TW]), 64'(3));
    rst = 1'b1;
    fu_done = 8'h0F;
    cycle("t36r");
    check("t36_rstwr", 64'(obs_wr), 64'(0));
    rst = 1'b0;
    fu_done = 8'h81;
    cycle("t36a");
    check("t36_ack", 64'(obs_ack), 64'(0));
    check("t36_idx0", 64'(obs_din[DW +: TW]), 64'(0));
    fu_done = 8'h80;
    cycle("t36b");
    fu_done = '0;
    pa = '0;
    for (int n = 0; n < 3000; n++) begin
      a = ack_exp();
      rst = $urandom_range(0, 99) == 0;
      queue_full = $urandom_range(0, 9) < 3;
      for (int i = 0; i < N; i++)
        if (rst) fu_done[i] = 1'b0;
        else if (a[i]) fu_done[i] = 1'($urandom_range(0, 1));
        else if (pa[i]) fu_done[i] = 1'b0;
        else if (!fu_done[i] && $urandom_range(0, 2) == 0) begin
          fu_done[i] = 1'b1;
          res[i] = $urandom;
          tag[i] = TW'($urandom);
        end
      pa = a;
      cycle("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fu_result_arbiter.md
FU_RESULT_ARBITER -- requirements
Module: fu_result_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 8, meaning number of functional-unit requesters, 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning result width per FU.
REQ-003 SHALL have parameter TAG_WIDTH, default 7, meaning execution-tag width per FU.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fu_done  input  NUM_FU  bit i high means FU i holds a valid result; it stays high until acked.
REQ-007 SHALL have port fu_result  input  NUM_FU*DATA_WIDTH  packed results; FU i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port fu_tag  input  NUM_FU*TAG_WIDTH  packed tags; FU i occupies slice [i*TAG_WIDTH +: TAG_WIDTH].
REQ-009 SHALL have port fu_ack  output  NUM_FU  registered; pulses one cycle after FU i's result is written to the broadcast queue.
REQ-010 SHALL have port queue_full  input  1  broadcast FIFO full.
REQ-011 SHALL have port q_wr_en  output  1  combinational FIFO write enable.
REQ-012 SHALL have port q_din  output  TAG_WIDTH+DATA_WIDTH  write data as {tag, result}.
REQ-013 SHALL have port stall_count  output  16  saturating count of cycles in which a request was blocked by queue_full.

Function
REQ-014 SHALL define eligible[i] = fu_done[i] & ~mask[i], where mask is the one-hot register of the FU granted in the previous cycle.
REQ-015 SHALL grant at most one FU per cycle, and only when queue_full=0 and at least one bit of eligible is set.
REQ-016 SHALL choose the grant round-robin: the first eligible index at or after ptr, wrapping from NUM_FU-1 to 0.
REQ-017 SHALL drive q_wr_en=1 and q_din={fu_tag[g], fu_result[g]} in the same cycle as the grant to FU g.
REQ-018 SHALL drive q_wr_en=0 and q_din=0 when there is no grant.
REQ-019 SHALL, on a grant to g, set ptr to (g+1) mod NUM_FU and set mask to one-hot g at the next edge; mask SHALL clear the following cycle unless a new grant occurs.
REQ-020 SHALL assert fu_ack[g]=1 for exactly one cycle, at the edge after the grant; all other fu_ack bits SHALL be 0.
REQ-021 SHALL exclude FU g from arbitration in the cycle its ack is high, so its still-high fu_done cannot cause a duplicate write.
REQ-022 SHALL hold ptr, issue no fu_ack, and increment stall_count by 1 (saturating at 0xFFFF) while queue_full=1 and any fu_done bit is set.
REQ-023 SHALL re-arbitrate from the held ptr in the first cycle after queue_full falls; no request SHALL be lost.
REQ-024 SHALL have a zero-cycle request-to-write latency and a one-cycle write-to-ack latency.
REQ-025 SHALL guarantee that any continuously asserted fu_done is granted within 2*NUM_FU cycles in which queue_full=0.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, reset ptr=0, mask=0, fu_ack=0 and stall_count=0.
REQ-027 SHALL force q_wr_en=0 whenever rst=1, regardless of fu_done.
REQ-028 SHALL, on reset mid-operation, drop any pending ack; FUs SHALL be reset by the same rst.

Structure
REQ-029 SHALL place shared constants in the core package: FU index constants (ADD, SUB, XOR, SRL, SRA, OR, AND), NUM_FU, and the queue-entry packing width TAG_WIDTH+DATA_WIDTH.
REQ-030 SHALL implement the rotating first-one search as one combinational sub-module, rr_priority_pick (inputs: request vector, ptr; outputs: valid, index).
REQ-031 SHALL place all sequential state (ptr, mask, fu_ack, stall_count) in this module.

Verification
REQ-032 SHALL check: fu_done=8'h01, result 0x1234, tag 5 -> q_wr_en=1, q_din={7'd5,32'h1234}; fu_ack=8'h01 next cycle; no second write.
REQ-033 SHALL check: fu_done=8'hFF held with each FU dropping done after its ack -> writes in index order 0..7 over 8 consecutive cycles, with each index written exactly once.
REQ-034 SHALL check: FU 2 and FU 6 done continuously, re-raised one cycle after ack -> grants alternate 2, 6, 2, 6, and neither FU goes more than 2 cycles without a grant.
REQ-035 SHALL check: queue_full=1 for 10 cycles with fu_done=8'h10 -> q_wr_en=0 and no ack throughout, stall_count=10, then a write of FU 4 in the cycle full deasserts.
REQ-036 SHALL check: rst asserted in the cycle after a grant to FU 3 -> fu_ack=0, ptr=0, and the first grant after reset starts search at index 0.
